// File: rtl/mem_ctl_pkg.sv
// mem_ctl_pkg: shared definitions for the memory access controller.
//   - Default address/data widths.
//   - Command op encodings (op_e).
//   - Controller state encoding (state_e). The MV_* states exist only when
//     MEMCTL_MOVE_EN is defined.
//   - Width of the read-latency counter (RD_LAT is at most 3).
package mem_ctl_pkg;

    localparam int unsigned DefAddrW = 10;
    localparam int unsigned DefDataW = 16;
    localparam int unsigned LatCntW  = 2;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_MOVE  = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StWr,
`ifdef MEMCTL_MOVE_EN
        StMvRd,
        StMvWait,
        StMvWr,
`endif
        StResp
    } state_e;

endpackage

// File: rtl/mem_ctl_lat_cnt.sv
// mem_ctl_lat_cnt: loadable down-counter used to time memory read latency.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset (count clears to 0)
//   load_i     load loadVal_i this cycle (has priority over dec_i)
//   loadVal_i  value to load
//   dec_i      decrement by one; saturates at 0
//   done_o     count is zero
module mem_ctl_lat_cnt #(
    parameter int unsigned Width = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] loadVal_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] cntQ;
    logic [Width-1:0] cntD;

    always_comb begin
        cntD = cntQ;
        if (load_i) begin
            cntD = loadVal_i;
        end else if (dec_i && (cntQ != '0)) begin
            cntD = cntQ - Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cntQ <= '0;
        end else begin
            cntQ <= cntD;
        end
    end

    assign done_o = (cntQ == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: initiator-side controller for the register/memory block.
// Accepts read/write/move commands over ReqValid/ReqReady, drives the memory
// port and returns one registered response (RspValid pulse) per command.
// Optional feature: block move (op 10) is built only when MEMCTL_MOVE_EN is
// defined; otherwise op 10 completes like the reserved op (RspErr=1).
// Ports:
//   CLK, Reset_n                  clock, asynchronous active-low reset
//   ReqValid/ReqReady             command handshake
//   ReqOp, ReqAddr, ReqDst,
//   ReqLen, ReqData               command fields, latched at accept
//   RspValid, RspData, RspErr     completion pulse, read/last-moved data, error
//   MemAddr, MemWData, MemWE      memory request lines
//   MemRData                      memory read data (RD_LAT edges after address)
//   Busy                          high whenever the controller is not idle
module mem_access_ctrl
    import mem_ctl_pkg::*;
#(
    parameter int unsigned ADDR_W = DefAddrW,
    parameter int unsigned DATA_W = DefDataW,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [1:0]        ReqOp,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [ADDR_W-1:0] ReqDst,
    input  logic [ADDR_W-1:0] ReqLen,
    input  logic [DATA_W-1:0] ReqData,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    output logic              RspErr,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              MemWE,
    input  logic [DATA_W-1:0] MemRData,
    output logic              Busy
);

    state_e               stateQ;
    logic                 accept;
    logic                 cntLoad;
    logic [LatCntW-1:0]   cntLoadVal;
    logic                 cntDec;
    logic                 cntDone;

`ifdef MEMCTL_MOVE_EN
    logic [ADDR_W-1:0]    srcQ;
    logic [ADDR_W-1:0]    dstQ;
    logic [ADDR_W-1:0]    lenQ;
`else
    logic                 unusedMv;
    assign unusedMv = ^{ReqDst, ReqLen};
`endif

    // ReqReady is registered and only ever high in StIdle.
    assign accept = ReqValid && ReqReady;

    // A read loads RD_LAT at accept (address goes out on the same edge, data
    // is sampled on the edge after the count expires). A move word loads
    // RD_LAT-1 on leaving MV_RD because MV_RD itself covers the first edge.
    always_comb begin
        cntLoad    = 1'b0;
        cntLoadVal = '0;
        cntDec     = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (accept && (ReqOp == OP_READ)) begin
                    cntLoad    = 1'b1;
                    cntLoadVal = LatCntW'(RD_LAT);
                end
            end
            StRdWait: cntDec = !cntDone;
`ifdef MEMCTL_MOVE_EN
            StMvRd: begin
                cntLoad    = 1'b1;
                cntLoadVal = LatCntW'(RD_LAT - 1);
            end
            StMvWait: cntDec = !cntDone;
`endif
            default: ;
        endcase
    end

    mem_ctl_lat_cnt #(
        .Width (LatCntW)
    ) uLatCnt (
        .clk_i     (CLK),
        .rst_ni    (Reset_n),
        .load_i    (cntLoad),
        .loadVal_i (cntLoadVal),
        .dec_i     (cntDec),
        .done_o    (cntDone)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            stateQ   <= StIdle;
            ReqReady <= 1'b0;
            RspValid <= 1'b0;
            RspData  <= '0;
            RspErr   <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemWE    <= 1'b0;
            Busy     <= 1'b0;
`ifdef MEMCTL_MOVE_EN
            srcQ     <= '0;
            dstQ     <= '0;
            lenQ     <= '0;
`endif
        end else begin
            RspValid <= 1'b0;
            MemWE    <= 1'b0;
            unique case (stateQ)
                StIdle: begin
                    ReqReady <= 1'b1;
                    Busy     <= 1'b0;
                    if (accept) begin
                        ReqReady <= 1'b0;
                        Busy     <= 1'b1;
                        case (op_e'(ReqOp))
                            OP_READ: begin
                                MemAddr <= ReqAddr;
                                stateQ  <= StRdWait;
                            end
                            OP_WRITE: begin
                                MemAddr  <= ReqAddr;
                                MemWData <= ReqData;
                                MemWE    <= 1'b1;
                                stateQ   <= StWr;
                            end
`ifdef MEMCTL_MOVE_EN
                            OP_MOVE: begin
                                if (ReqLen == '0) begin
                                    RspValid <= 1'b1;
                                    RspErr   <= 1'b0;
                                    stateQ   <= StResp;
                                end else begin
                                    MemAddr <= ReqAddr;
                                    srcQ    <= ReqAddr;
                                    dstQ    <= ReqDst;
                                    lenQ    <= ReqLen;
                                    stateQ  <= StMvRd;
                                end
                            end
`endif
                            default: begin
                                RspValid <= 1'b1;
                                RspErr   <= 1'b1;
                                stateQ   <= StResp;
                            end
                        endcase
                    end
                end
                StRdWait: begin
                    if (cntDone) begin
                        RspData  <= MemRData;
                        RspValid <= 1'b1;
                        RspErr   <= 1'b0;
                        stateQ   <= StResp;
                    end
                end
                StWr: begin
                    RspValid <= 1'b1;
                    RspErr   <= 1'b0;
                    stateQ   <= StResp;
                end
`ifdef MEMCTL_MOVE_EN
                StMvRd: stateQ <= StMvWait;
                StMvWait: begin
                    if (cntDone) begin
                        MemAddr  <= dstQ;
                        MemWData <= MemRData;
                        MemWE    <= 1'b1;
                        stateQ   <= StMvWr;
                    end
                end
                StMvWr: begin
                    srcQ <= srcQ + ADDR_W'(1);
                    dstQ <= dstQ + ADDR_W'(1);
                    lenQ <= lenQ - ADDR_W'(1);
                    if (lenQ == ADDR_W'(1)) begin
                        RspData  <= MemWData;
                        RspValid <= 1'b1;
                        RspErr   <= 1'b0;
                        stateQ   <= StResp;
                    end else begin
                        // Next source address goes out as MV_RD is entered.
                        MemAddr <= srcQ + ADDR_W'(1);
                        stateQ  <= StMvRd;
                    end
                end
`endif
                StResp: begin
                    ReqReady <= 1'b1;
                    Busy     <= 1'b0;
                    stateQ   <= StIdle;
                end
                default: begin
                    ReqReady <= 1'b1;
                    Busy     <= 1'b0;
                    stateQ   <= StIdle;
                end
            endcase
        end
    end

endmodule
